// File: rtl/store_buffer_pkg.sv
// Shared types and sizing helpers for the posted-write store buffer.
// The entry layout fixes the address/data widths used by every instance.
package store_buffer_pkg;

  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;
  localparam int WORD_LSB  = 2;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline-side load/store port and memory-side read/write port of the store buffer.
// slave is the buffer's view; master is the pipeline/memory view.
interface store_buffer_if #(
  parameter int ADDR_W = store_buffer_pkg::SB_ADDR_W,
  parameter int DATA_W = store_buffer_pkg::SB_DATA_W
);

  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_write_enable;
  logic [DATA_W-1:0] cpu_write_data;
  logic [DATA_W-1:0] cpu_read_data;
  logic              stall;
  logic              empty;
  logic [ADDR_W-1:0] mem_read_addr;
  logic [DATA_W-1:0] mem_read_data;
  logic              mem_write_valid;
  logic              mem_write_ready;
  logic [ADDR_W-1:0] mem_write_addr;
  logic [DATA_W-1:0] mem_write_data;

  modport slave (
    input  cpu_addr, cpu_write_enable, cpu_write_data, mem_read_data, mem_write_ready,
    output cpu_read_data, stall, empty, mem_read_addr,
           mem_write_valid, mem_write_addr, mem_write_data
  );

  modport master (
    output cpu_addr, cpu_write_enable, cpu_write_data, mem_read_data, mem_write_ready,
    input  cpu_read_data, stall, empty, mem_read_addr,
           mem_write_valid, mem_write_addr, mem_write_data
  );

endinterface

// File: rtl/store_buffer_match.sv
// Combinational youngest-match search over the buffered stores (word granularity).
// Entries are scanned oldest to youngest so the last hit found is the youngest.
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = ptr_width(DEPTH)
) (
  input  sb_entry_t            entries_i [DEPTH],
  input  logic [DEPTH-1:0]     valid_i,
  input  logic [PTR_W-1:0]     head_i,
  input  logic [SB_ADDR_W-1:0] cpu_addr_i,
  output logic                 hit_o,
  output logic [SB_DATA_W-1:0] data_o
);

  logic [PTR_W-1:0] idx;

  // NOTE: every output of a combinational block gets a default before any branch, so no latch is inferred.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PTR_W'(k);
      // XOR then shift drops the byte offset so any address within the word matches.
      if (valid_i[idx] && (((entries_i[idx].addr ^ cpu_addr_i) >> WORD_LSB) == '0)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: circular FIFO of full-word stores drained in order
// to memory, with youngest-store forwarding to loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input logic          clk,
  input logic          rst_n,
  store_buffer_if.slave bus
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  sb_entry_t         entries_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  valid;
  logic              full, push, pop, hit;
  logic [DATA_W-1:0] fwd_data;
  logic [ADDR_W-1:0] load_addr;

  assign load_addr = bus.cpu_addr;
  assign full      = (count_q == CNT_W'(DEPTH));
  assign push      = bus.cpu_write_enable && !full;
  assign pop       = (count_q != '0) && bus.mem_write_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: entry storage is deliberately unreset; the valid mask derived from head/count hides stale contents.
  always_ff @(posedge clk) begin
    if (push) entries_q[tail_q] <= '{addr: bus.cpu_addr, data: bus.cpu_write_data};
  end

  // Slot i is live when its distance from head (mod DEPTH) is below count.
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = ({1'b0, PTR_W'(PTR_W'(i) - head_q)} < count_q);
    end
  end

  store_buffer_match #(.DEPTH(DEPTH)) u_match (
    .entries_i  (entries_q),
    .valid_i    (valid),
    .head_i     (head_q),
    .cpu_addr_i (load_addr),
    .hit_o      (hit),
    .data_o     (fwd_data)
  );

  assign bus.stall           = bus.cpu_write_enable && full;
  assign bus.empty           = (count_q == '0);
  assign bus.mem_write_valid = (count_q != '0);
  assign bus.mem_write_addr  = entries_q[head_q].addr;
  assign bus.mem_write_data  = entries_q[head_q].data;
  assign bus.mem_read_addr   = load_addr;
  assign bus.cpu_read_data   = hit ? fwd_data : bus.mem_read_data;

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: a per-cycle vector table plus
// hand-written full/stall, streaming and reset-mid-drain sequences.
module tb_store_buffer;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  store_buffer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] mrdata;
    logic        exp_stall;
    logic        exp_valid;
    logic        exp_empty;
    logic [31:0] exp_waddr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic ready, input logic [31:0] mrdata);
    bus.cpu_write_enable = we;
    bus.cpu_addr         = addr;
    bus.cpu_write_data   = wdata;
    bus.mem_write_ready  = ready;
    bus.mem_read_data    = mrdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            we  addr        wdata         rdy mrdata        stl vld emp waddr       wdata         rdata
    vecs[0]  = '{1'b0, 32'h100, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,   32'h0,        32'h0};
    vecs[1]  = '{1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,   32'h0,        32'h0};
    vecs[2]  = '{1'b0, 32'h100, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 32'h300, 32'h0,        1'b1, 32'h55,       1'b0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 32'h55};
    vecs[4]  = '{1'b1, 32'h104, 32'h1111,     1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,   32'h0,        32'h0};
    vecs[5]  = '{1'b1, 32'h104, 32'h2222,     1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h104, 32'h1111,     32'h1111};
    vecs[6]  = '{1'b0, 32'h106, 32'h0,        1'b0, 32'h77,       1'b0, 1'b1, 1'b0, 32'h104, 32'h1111,     32'h2222};
    vecs[7]  = '{1'b0, 32'h106, 32'h0,        1'b1, 32'h77,       1'b0, 1'b1, 1'b0, 32'h104, 32'h1111,     32'h2222};
    vecs[8]  = '{1'b0, 32'h104, 32'h0,        1'b1, 32'h77,       1'b0, 1'b1, 1'b0, 32'h104, 32'h2222,     32'h2222};
    vecs[9]  = '{1'b0, 32'h104, 32'h0,        1'b1, 32'h77,       1'b0, 1'b0, 1'b1, 32'h0,   32'h0,        32'h77};
    vecs[10] = '{1'b0, 32'h200, 32'h0,        1'b0, 32'hCAFE0000, 1'b0, 1'b0, 1'b1, 32'h0,   32'h0,        32'hCAFE0000};

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset valid", 32'(bus.mem_write_valid), 32'd0);
    check("reset empty", 32'(bus.empty), 32'd1);
    check("reset stall", 32'(bus.stall), 32'd0);
    check("reset mem_read_addr", bus.mem_read_addr, 32'h0);
    next_cycle();

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ready, vecs[i].mrdata);
      @(negedge clk);
      check($sformatf("vec%0d stall", i), 32'(bus.stall), 32'(vecs[i].exp_stall));
      check($sformatf("vec%0d valid", i), 32'(bus.mem_write_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d empty", i), 32'(bus.empty), 32'(vecs[i].exp_empty));
      check($sformatf("vec%0d rdata", i), bus.cpu_read_data, vecs[i].exp_rdata);
      check($sformatf("vec%0d raddr", i), bus.mem_read_addr, vecs[i].addr);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d waddr", i), bus.mem_write_addr, vecs[i].exp_waddr);
        check($sformatf("vec%0d wdata", i), bus.mem_write_data, vecs[i].exp_wdata);
      end
      next_cycle();
    end

    // Fill to DEPTH, then a stalled fifth store with and without a same-cycle pop.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h400 + 32'(4 * k), 32'(k + 1), 1'b0, 32'h0);
      @(negedge clk);
      check($sformatf("fill%0d stall", k), 32'(bus.stall), 32'd0);
      next_cycle();
    end
    drive(1'b1, 32'h410, 32'd5, 1'b0, 32'h0);
    @(negedge clk);
    check("full stall", 32'(bus.stall), 32'd1);
    next_cycle();
    check("full count", 32'(dut.count_q), 32'd4);
    check("full head", bus.mem_write_addr, 32'h400);
    drive(1'b1, 32'h410, 32'd5, 1'b1, 32'h0);
    @(negedge clk);
    check("full+pop stall", 32'(bus.stall), 32'd1);
    next_cycle();
    check("full+pop count", 32'(dut.count_q), 32'd3);
    check("full+pop head", bus.mem_write_addr, 32'h404);
    drive(1'b1, 32'h410, 32'd5, 1'b0, 32'h0);
    @(negedge clk);
    check("retry stall", 32'(bus.stall), 32'd0);
    next_cycle();
    check("retry count", 32'(dut.count_q), 32'd4);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h410, 32'h0, 1'b1, 32'hABCD);
      @(negedge clk);
      check($sformatf("drain%0d valid", k), 32'(bus.mem_write_valid), 32'd1);
      check($sformatf("drain%0d waddr", k), bus.mem_write_addr, 32'h404 + 32'(4 * k));
      check($sformatf("drain%0d wdata", k), bus.mem_write_data, 32'(k + 2));
      check($sformatf("drain%0d fwd", k), bus.cpu_read_data, 32'd5);
      next_cycle();
    end
    check("drained empty", 32'(bus.empty), 32'd1);
    check("drained rdata", bus.cpu_read_data, 32'hABCD);

    // Streaming push+pop every cycle; pointers wrap several times.
    drive(1'b1, 32'h1000, 32'h100, 1'b1, 32'h0);
    @(negedge clk);
    check("stream0 valid", 32'(bus.mem_write_valid), 32'd0);
    next_cycle();
    for (int k = 1; k <= 20; k++) begin
      drive(1'b1, 32'h1000 + 32'(4 * k), 32'h100 + 32'(k), 1'b1, 32'h0);
      @(negedge clk);
      check($sformatf("stream%0d valid", k), 32'(bus.mem_write_valid), 32'd1);
      check($sformatf("stream%0d waddr", k), bus.mem_write_addr, 32'h1000 + 32'(4 * (k - 1)));
      check($sformatf("stream%0d wdata", k), bus.mem_write_data, 32'h100 + 32'(k - 1));
      next_cycle();
      check($sformatf("stream%0d count", k), 32'(dut.count_q), 32'd1);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    @(negedge clk);
    check("stream tail waddr", bus.mem_write_addr, 32'h1050);
    next_cycle();
    check("stream empty", 32'(bus.empty), 32'd1);

    // Reset mid-drain discards pending stores immediately.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h500 + 32'(4 * k), 32'hA0 + 32'(k), 1'b0, 32'h0);
      next_cycle();
    end
    drive(1'b0, 32'h504, 32'h0, 1'b0, 32'h99);
    @(negedge clk);
    check("pre-rst valid", 32'(bus.mem_write_valid), 32'd1);
    check("pre-rst fwd", bus.cpu_read_data, 32'hA1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst valid", 32'(bus.mem_write_valid), 32'd0);
    check("rst empty", 32'(bus.empty), 32'd1);
    check("rst rdata", bus.cpu_read_data, 32'h99);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-rst rdata", bus.cpu_read_data, 32'h99);
    check("post-rst empty", 32'(bus.empty), 32'd1);
    next_cycle();
    check("post-rst valid", 32'(bus.mem_write_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
